regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Owns the single write port of the 32x32 register file. After reset it sequences a
//  clear of every register, then arbitrates writebacks between the ALU stage and the
//  memory-load return path, which is buffered in a small FIFO.
//  Also suppresses x0 writes and reports pending destination registers to hazard logic.
// PARAMETERS
//  XLEN      32  data width
//  NREG      32  number of registers cleared during INIT
//  AW        5   register index width
//  LQ_DEPTH  2   load-return buffer entries (>=1)
// PORTS
//  CLK          in   1     clock; all state updates on posedge
//  RST          in   1     reset, asynchronous, active-high
//  alu_valid    in   1     ALU writeback request
//  alu_rd       in   AW    ALU destination register
//  alu_data     in   XLEN  ALU result
//  alu_ready    out  1     ALU request accepted this cycle when alu_valid & alu_ready
//  mem_valid    in   1     load-return writeback request
//  mem_rd       in   AW    load destination register
//  mem_data     in   XLEN  load data
//  mem_ready    out  1     load request accepted into buffer when mem_valid & mem_ready
//  chk_rs1      in   AW    hazard query index 1
//  chk_rs2      in   AW    hazard query index 2
//  pend_rs1     out  1     chk_rs1 has a write not yet committed to the regfile
//  pend_rs2     out  1     chk_rs2 has a write not yet committed to the regfile
//  rf_rd        out  AW    to regfile rd
//  rf_indata    out  XLEN  to regfile indata
//  rf_RegWrite  out  1     to regfile RegWrite
//  init_done    out  1     high once the clear sequence completes
// BEHAVIOUR
//  - Reset (async, RST=1):
//    - state=INIT, init_cnt=0, buffer empty, init_done=0.
//    - rf_RegWrite=0, rf_rd=0, rf_indata=0.
//    - alu_ready=0, mem_ready=0.
//  - INIT:
//    - Each cycle, registered outputs are rf_RegWrite=1, rf_rd=init_cnt, rf_indata=0;
//      init_cnt then increments.
//    - x0 is written with 0 on purpose.
//    - After the write with init_cnt=NREG-1, state moves to RUN; init_done=1 from the
//      next cycle.
//    - The sequence takes NREG write cycles after RST falls.
//    - alu_ready=mem_ready=0 throughout INIT.
//  - RUN, ports:
//    - rf_* outputs are registered: an accepted or drained write appears on rf_* one
//      cycle later.
//    - The regfile commits it on the following edge.
//    - mem_ready = !full (combinational from buffer count).
//    - alu_ready = !full.
//  - RUN, arbitration, each cycle in priority order:
//    - (a) Buffer full: drain head, alu_ready=0.
//    - (b) Else alu_valid: issue the ALU write; the buffer does not drain.
//    - (c) Else buffer non-empty: drain head.
//    - (d) Else rf_RegWrite=0.
//  - RUN, buffer:
//    - Enqueue and dequeue in the same cycle are allowed when not full; count is
//      unchanged.
//    - Buffer is strictly FIFO.
//  - x0: a request with rd=0 completes its handshake but issues rf_RegWrite=0.
//    rf_rd/rf_indata still update.
//  - Same-rd ordering: buffered load entries are older than any ALU writeback.
//    - On ALU accept, every valid buffer entry with the same rd is killed.
//    - A killed entry still dequeues in order, with rf_RegWrite=0.
//    - A load enqueued in the same cycle as a matching ALU accept is not killed.
//  - pend_rsN (combinational) is 1 when chk_rsN != 0 and any of these match chk_rsN:
//    - a live (not killed) buffer entry;
//    - the registered rf_rd while rf_RegWrite=1.
//  - Reset mid-operation: buffered entries are discarded and the INIT sequence
//    restarts from 0.
// STRUCTURE
//  - Package rf_wb_pkg holds:
//    - state enum {ST_INIT, ST_RUN};
//    - struct wb_req_t {rd, data};
//    - constants XLEN, AW, NREG.
//  - Sub-module wb_fifo: LQ_DEPTH-entry FIFO with per-entry live bits.
//    - Ports: push/pop, full/empty, head, kill_en + kill_rd, match query
//      (rd -> any live).
//  - Top level: state machine, init counter, arbiter, output registers.
// TESTING
//  1. Release RST -> 32 consecutive cycles rf_RegWrite=1, rf_rd=0..31, rf_indata=0.
//     Then init_done=1, alu_ready=mem_ready=1.
//     Assert RST at init_cnt=10 -> outputs zero at once; the sequence restarts at rd=0.
//  2. alu_valid, rd=5, data=0xDEADBEEF -> next cycle rf_RegWrite=1, rf_rd=5,
//     rf_indata=0xDEADBEEF.
//     ALU rd=0, data=0x1234 -> handshake completes; rf_RegWrite stays 0.
//  3. Same cycle: mem rd=7/0x77 and ALU rd=3/0x33 -> rd=3 written first, rd=7 the
//     following cycle.
//     pend_rs1 (chk_rs1=7) is 1 until that write has committed.
//  4. Two loads while ALU streams every cycle:
//     - buffer full -> mem_ready=0, alu_ready=0 for one cycle;
//     - the head drains in FIFO order;
//     - no request is lost or duplicated.
//  5. Load rd=9/0x99 buffered, then ALU rd=9/0xAA accepted:
//     - only the 0xAA write carries rf_RegWrite=1;
//     - the killed entry drains with rf_RegWrite=0;
//     - pend_rs1 (chk_rs1=9) is 1 while rd=9/0xAA is on rf_*, 0 once it commits.
//  6. Random alu/mem traffic against a reference regfile model -> final register
//     contents match.
//     Also check: x0 is never written after INIT; alu_ready/mem_ready never high
//     while full.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared types and constants for the writeback arbiter
package rf_wb_pkg;
   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NREG = 32;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   typedef struct packed {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request, hazard query and regfile write bundle
interface regfile_wb_arbiter_if;
   import rf_wb_pkg::*;

   logic            alu_valid;
   logic [AW-1:0]   alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            alu_ready;
   logic            mem_valid;
   logic [AW-1:0]   mem_rd;
   logic [XLEN-1:0] mem_data;
   logic            mem_ready;
   logic [AW-1:0]   chk_rs1;
   logic [AW-1:0]   chk_rs2;
   logic            pend_rs1;
   logic            pend_rs2;
   logic [AW-1:0]   rf_rd;
   logic [XLEN-1:0] rf_indata;
   logic            rf_RegWrite;
   logic            init_done;

   modport slave (
      input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_rs1, chk_rs2,
      output alu_ready, mem_ready, pend_rs1, pend_rs2, rf_rd, rf_indata, rf_RegWrite, init_done
   );

   modport master (
      output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_rs1, chk_rs2,
      input  alu_ready, mem_ready, pend_rs1, pend_rs2, rf_rd, rf_indata, rf_RegWrite, init_done
   );
endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// rtl/regfile_wb_arbiter_fifo.sv - load-return FIFO with per-entry live bits
// A killed entry keeps its slot so it still drains in order, just without writing.
module wb_fifo
   import rf_wb_pkg::*;
#(
   parameter int LQ_DEPTH = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  wb_req_t       i_push_req,
   input  logic          i_pop,
   output logic          o_full,
   output logic          o_empty,
   output wb_req_t       o_head,
   output logic          o_head_live,
   input  logic          i_kill_en,
   input  logic [AW-1:0] i_kill_rd,
   input  logic [AW-1:0] i_q1_rd,
   output logic          o_q1_hit,
   input  logic [AW-1:0] i_q2_rd,
   output logic          o_q2_hit
);
   localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
   localparam int CW = $clog2(LQ_DEPTH + 1);

   wb_req_t             r_mem [LQ_DEPTH];
   logic [LQ_DEPTH-1:0] r_live;
   logic [PW-1:0]       r_wptr;
   logic [PW-1:0]       r_rptr;
   logic [CW-1:0]       r_cnt;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wptr] <= i_push_req;
   end

   // Push is applied after kill so a same-cycle load with a matching rd stays live.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_live <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         for (int i = 0; i < LQ_DEPTH; i++) begin
            if (i_kill_en && r_mem[i].rd == i_kill_rd) r_live[i] <= 1'b0;
         end
         if (i_pop) begin
            r_live[r_rptr] <= 1'b0;
            r_rptr         <= f_inc(r_rptr);
         end
         if (i_push) begin
            r_live[r_wptr] <= 1'b1;
            r_wptr         <= f_inc(r_wptr);
         end
         r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
      end
   end

   assign o_full      = (r_cnt == CW'(LQ_DEPTH));
   assign o_empty     = (r_cnt == '0);
   assign o_head      = r_mem[r_rptr];
   assign o_head_live = r_live[r_rptr];

   always_comb begin
      o_q1_hit = 1'b0;
      o_q2_hit = 1'b0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         if (r_live[i] && r_mem[i].rd == i_q1_rd) o_q1_hit = 1'b1;
         if (r_live[i] && r_mem[i].rd == i_q2_rd) o_q2_hit = 1'b1;
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - regfile write-port owner: clear sequence, then ALU/load arbitration
module regfile_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int LQ_DEPTH = 2
) (
   input logic                  CLK,
   input logic                  RST,
   regfile_wb_arbiter_if.slave  bus
);
   state_t          r_state, w_state_nxt;
   logic [AW-1:0]   r_init_cnt, w_init_cnt_nxt;
   logic            r_rf_we, w_rf_we_nxt;
   logic [AW-1:0]   r_rf_rd, w_rf_rd_nxt;
   logic [XLEN-1:0] r_rf_data, w_rf_data_nxt;

   logic    w_run, w_full, w_empty, w_head_live;
   logic    w_alu_acc, w_push, w_pop, w_q1_hit, w_q2_hit;
   wb_req_t w_head, w_push_req;

   assign w_run      = (r_state == ST_RUN);
   assign w_alu_acc  = w_run && bus.alu_valid && !w_full;
   assign w_push     = w_run && bus.mem_valid && !w_full;
   // A full buffer takes the port so the ALU can never starve the load path.
   assign w_pop      = w_run && (w_full || (!bus.alu_valid && !w_empty));
   assign w_push_req = '{rd: bus.mem_rd, data: bus.mem_data};

   wb_fifo #(.LQ_DEPTH(LQ_DEPTH)) u_fifo (
      .i_clk       (CLK),
      .i_rst       (RST),
      .i_push      (w_push),
      .i_push_req  (w_push_req),
      .i_pop       (w_pop),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (w_head),
      .o_head_live (w_head_live),
      .i_kill_en   (w_alu_acc),
      .i_kill_rd   (bus.alu_rd),
      .i_q1_rd     (bus.chk_rs1),
      .o_q1_hit    (w_q1_hit),
      .i_q2_rd     (bus.chk_rs2),
      .o_q2_hit    (w_q2_hit)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= ST_INIT;
         r_init_cnt <= '0;
         r_rf_we    <= 1'b0;
         r_rf_rd    <= '0;
         r_rf_data  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_cnt <= w_init_cnt_nxt;
         r_rf_we    <= w_rf_we_nxt;
         r_rf_rd    <= w_rf_rd_nxt;
         r_rf_data  <= w_rf_data_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_init_cnt_nxt = r_init_cnt;
      w_rf_we_nxt    = 1'b0;
      w_rf_rd_nxt    = r_rf_rd;
      w_rf_data_nxt  = r_rf_data;
      case (r_state)
         ST_INIT: begin
            w_rf_we_nxt    = 1'b1;
            w_rf_rd_nxt    = r_init_cnt;
            w_rf_data_nxt  = '0;
            w_init_cnt_nxt = r_init_cnt + 1'b1;
            if (r_init_cnt == AW'(NREG - 1)) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (w_alu_acc) begin
               w_rf_we_nxt   = (bus.alu_rd != '0);
               w_rf_rd_nxt   = bus.alu_rd;
               w_rf_data_nxt = bus.alu_data;
            end else if (w_pop) begin
               w_rf_we_nxt   = w_head_live && (w_head.rd != '0);
               w_rf_rd_nxt   = w_head.rd;
               w_rf_data_nxt = w_head.data;
            end
         end
      endcase
   end

   assign bus.alu_ready   = w_run && !w_full;
   assign bus.mem_ready   = w_run && !w_full;
   assign bus.init_done   = w_run;
   assign bus.rf_RegWrite = r_rf_we;
   assign bus.rf_rd       = r_rf_rd;
   assign bus.rf_indata   = r_rf_data;
   assign bus.pend_rs1    = (bus.chk_rs1 != '0) &&
                            (w_q1_hit || (r_rf_we && r_rf_rd == bus.chk_rs1));
   assign bus.pend_rs2    = (bus.chk_rs2 != '0) &&
                            (w_q2_hit || (r_rf_we && r_rf_rd == bus.chk_rs2));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and random checks of the writeback arbiter
module tb_regfile_wb_arbiter;
   import rf_wb_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_vec   = 0;
   int   n_err   = 0;
   int   x0_viol = 0;
   int   tb_cnt;
   logic [XLEN-1:0] tb_rf  [NREG];
   logic [XLEN-1:0] ref_rf [NREG];

   regfile_wb_arbiter_if bus();

   regfile_wb_arbiter #(.LQ_DEPTH(2)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (bus.rf_RegWrite) tb_rf[bus.rf_rd] <= bus.rf_indata;
   end

   always @(negedge CLK) begin
      if (bus.init_done && bus.rf_RegWrite && bus.rf_rd == '0) x0_viol <= x0_viol + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle;
      bus.alu_valid = 1'b0;
      bus.mem_valid = 1'b0;
   endtask

   task automatic drive_alu(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
      bus.alu_valid = 1'b1;
      bus.alu_rd    = rd;
      bus.alu_data  = d;
   endtask

   task automatic drive_mem(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
      bus.mem_valid = 1'b1;
      bus.mem_rd    = rd;
      bus.mem_data  = d;
   endtask

   initial begin
      bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
      bus.chk_rs1 = '0; bus.chk_rs2 = '0;

      // reset state
      repeat (2) step;
      chk("rst_we", bus.rf_RegWrite, 0);
      chk("rst_rd", bus.rf_rd, 0);
      chk("rst_data", bus.rf_indata, 0);
      chk("rst_done", bus.init_done, 0);
      chk("rst_alu_rdy", bus.alu_ready, 0);
      chk("rst_mem_rdy", bus.mem_ready, 0);

      // clear sequence aborted at init_cnt=10
      RST = 1'b0;
      for (int i = 0; i < 10; i++) step;
      chk("pre_abort_rd", bus.rf_rd, 9);
      chk("pre_abort_rdy", bus.alu_ready, 0);
      RST = 1'b1;
      #1;
      chk("abort_we", bus.rf_RegWrite, 0);
      chk("abort_rd", bus.rf_rd, 0);
      step;
      RST = 1'b0;
      for (int i = 0; i < 32; i++) begin
         step;
         chk("init_we", bus.rf_RegWrite, 1);
         chk("init_rd", bus.rf_rd, i);
         chk("init_data", bus.rf_indata, 0);
         chk("init_done", bus.init_done, (i == 31));
      end
      chk("run_alu_rdy", bus.alu_ready, 1);
      chk("run_mem_rdy", bus.mem_ready, 1);

      // ALU write, then x0 write
      bus.chk_rs1 = 5'd5;
      drive_alu(5'd5, 32'hDEADBEEF);
      step;
      chk("alu5_we", bus.rf_RegWrite, 1);
      chk("alu5_rd", bus.rf_rd, 5);
      chk("alu5_data", bus.rf_indata, 32'hDEADBEEF);
      chk("alu5_pend", bus.pend_rs1, 1);
      drive_alu(5'd0, 32'h1234);
      #1;
      chk("x0_alu_rdy", bus.alu_ready, 1);
      step;
      chk("x0_we", bus.rf_RegWrite, 0);
      chk("x0_rd", bus.rf_rd, 0);
      chk("x0_data", bus.rf_indata, 32'h1234);
      chk("x0_commit5", tb_rf[5], 32'hDEADBEEF);
      idle;
      step;
      chk("idle_we", bus.rf_RegWrite, 0);

      // simultaneous load and ALU: ALU first, load next
      bus.chk_rs1 = 5'd7;
      bus.chk_rs2 = 5'd3;
      drive_mem(5'd7, 32'h77);
      drive_alu(5'd3, 32'h33);
      #1;
      chk("t3_pend_pre", bus.pend_rs1, 0);
      chk("t3_alu_rdy", bus.alu_ready, 1);
      chk("t3_mem_rdy", bus.mem_ready, 1);
      step;
      chk("t3_rd3", bus.rf_rd, 3);
      chk("t3_data3", bus.rf_indata, 32'h33);
      chk("t3_pend_rs2", bus.pend_rs2, 1);
      idle;
      #1;
      chk("t3_pend_buf", bus.pend_rs1, 1);
      step;
      chk("t3_we7", bus.rf_RegWrite, 1);
      chk("t3_rd7", bus.rf_rd, 7);
      chk("t3_data7", bus.rf_indata, 32'h77);
      chk("t3_pend_rf", bus.pend_rs1, 1);
      step;
      chk("t3_we_idle", bus.rf_RegWrite, 0);
      chk("t3_pend_done", bus.pend_rs1, 0);
      chk("t3_commit7", tb_rf[7], 32'h77);
      chk("t3_commit3", tb_rf[3], 32'h33);

      // two loads while ALU streams; buffer fills
      drive_alu(5'd10, 32'hA0);
      drive_mem(5'd11, 32'hB1);
      step;
      chk("t4_rd10", bus.rf_rd, 10);
      chk("t4_data10", bus.rf_indata, 32'hA0);
      drive_alu(5'd12, 32'hC2);
      drive_mem(5'd13, 32'hD3);
      step;
      chk("t4_rd12", bus.rf_rd, 12);
      drive_alu(5'd14, 32'hE4);
      bus.mem_valid = 1'b0;
      #1;
      chk("t4_full_alu_rdy", bus.alu_ready, 0);
      chk("t4_full_mem_rdy", bus.mem_ready, 0);
      step;
      chk("t4_we11", bus.rf_RegWrite, 1);
      chk("t4_rd11", bus.rf_rd, 11);
      chk("t4_data11", bus.rf_indata, 32'hB1);
      chk("t4_alu_rdy_again", bus.alu_ready, 1);
      step;
      chk("t4_rd14", bus.rf_rd, 14);
      chk("t4_data14", bus.rf_indata, 32'hE4);
      idle;
      step;
      chk("t4_we13", bus.rf_RegWrite, 1);
      chk("t4_rd13", bus.rf_rd, 13);
      chk("t4_data13", bus.rf_indata, 32'hD3);
      step;
      chk("t4_drained", bus.rf_RegWrite, 0);

      // buffered load killed by younger ALU write to same rd
      bus.chk_rs1 = 5'd9;
      drive_mem(5'd9, 32'h99);
      step;
      idle;
      drive_alu(5'd9, 32'hAA);
      #1;
      chk("t5_pend_buf", bus.pend_rs1, 1);
      step;
      chk("t5_weAA", bus.rf_RegWrite, 1);
      chk("t5_dataAA", bus.rf_indata, 32'hAA);
      idle;
      #1;
      chk("t5_pend_rf", bus.pend_rs1, 1);
      step;
      chk("t5_kill_we", bus.rf_RegWrite, 0);
      chk("t5_kill_rd", bus.rf_rd, 9);
      chk("t5_kill_data", bus.rf_indata, 32'h99);
      chk("t5_pend_done", bus.pend_rs1, 0);
      step;
      chk("t5_commit9", tb_rf[9], 32'hAA);

      // random traffic from a fresh clear
      RST = 1'b1;
      #1;
      step;
      RST = 1'b0;
      repeat (32) step;
      for (int r = 0; r < NREG; r++) ref_rf[r] = '0;
      tb_cnt = 0;
      for (int c = 0; c < 300; c++) begin
         bus.alu_valid = ($urandom_range(0, 99) < 55);
         bus.alu_rd    = AW'($urandom_range(0, 31));
         bus.alu_data  = $urandom();
         bus.mem_valid = ($urandom_range(0, 99) < 50);
         bus.mem_rd    = AW'($urandom_range(0, 31));
         bus.mem_data  = $urandom();
         bus.chk_rs1   = AW'($urandom_range(0, 31));
         bus.chk_rs2   = AW'($urandom_range(0, 31));
         #1;
         chk("rnd_alu_rdy", bus.alu_ready, (tb_cnt != 2));
         chk("rnd_mem_rdy", bus.mem_ready, (tb_cnt != 2));
         if (tb_cnt != 2) begin
            if (bus.alu_valid && bus.alu_rd != '0) ref_rf[bus.alu_rd] = bus.alu_data;
            if (bus.mem_valid && bus.mem_rd != '0) ref_rf[bus.mem_rd] = bus.mem_data;
         end
         tb_cnt = tb_cnt + ((bus.mem_valid && tb_cnt != 2) ? 1 : 0)
                         - ((tb_cnt == 2 || (!bus.alu_valid && tb_cnt > 0)) ? 1 : 0);
         step;
      end
      idle;
      repeat (4) step;
      for (int r = 0; r < NREG; r++) chk("rnd_regfile", tb_rf[r], ref_rf[r]);
      chk("x0_never_written", x0_viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
